// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared definitions for the HD44780-compatible character LCD controller:
//   - lcd_state_t : controller / bus-strobe state encoding
//   - HD44780 instruction bytes used by the init ROM and the autowrap logic
//   - delay constants in nanoseconds
//   - cyc()/div_cyc()/max3() constant helpers that turn delays into clock cycles
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_EHOLD,
        S_EXEC
    } lcd_state_t;

    // HD44780 instructions
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] HOME       = 8'h02;
    localparam logic [7:0] ENTRY_INC  = 8'h06;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] DISP_OFF   = 8'h08;
    localparam logic [7:0] FSET_4B    = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] FSET_8B    = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] FSET_N_BIT = 8'h08;  // cleared for a 1-line display
    localparam logic [7:0] DDRAM_L0   = 8'h80;
    localparam logic [7:0] DDRAM_L1   = 8'hC0;

    // Controller delays in ns
    localparam longint unsigned T_PWRUP_NS = 64'd15_000_000;
    localparam longint unsigned T_WAKE1_NS = 64'd4_100_000;
    localparam longint unsigned T_WAKE2_NS = 64'd100_000;
    localparam longint unsigned T_CLEAR_NS = 64'd1_640_000;
    localparam longint unsigned T_EXEC_NS  = 64'd40_000;

    // ceil(ns * clk_hz / 1e9); 64-bit product keeps 15 ms at several GHz exact
    function automatic int unsigned cyc(input longint unsigned ns,
                                        input longint unsigned clk_hz);
        longint unsigned c;
        c = (ns * clk_hz + 64'd999_999_999) / 64'd1_000_000_000;
        return 32'(c);
    endfunction

    // Floor division with a 1-cycle minimum so no wait ever degenerates to zero
    function automatic int unsigned div_cyc(input int unsigned c,
                                            input int unsigned div);
        int unsigned d;
        d = (div == 0) ? c : c / div;
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_bus_strobe.sv
// lcd_bus_strobe
// Drives one write cycle on the LCD bus: setup (rs/data valid, E low),
// E high pulse, then E low hold. The nibble/byte and rs are latched on
// start and stay stable until the next start, so they cover the whole cycle.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle request, honoured only when idle
//   rs, data        : register select and bus value for this pulse
//   done            : high for the last hold cycle (one cycle)
//   lcd_data/e/rs   : registered LCD pins
module lcd_bus_strobe
    import lcd_pkg::*;
#(
    parameter int          BUS_WIDTH = 4,
    parameter int unsigned SETUP_CYC = 20,
    parameter int unsigned EPW_CYC   = 100,
    parameter int unsigned HOLD_CYC  = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 rs,
    input  logic [BUS_WIDTH-1:0] data,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] lcd_data,
    output logic                 lcd_e,
    output logic                 lcd_rs
);

    localparam int unsigned MAX_CYC = max3(SETUP_CYC, EPW_CYC, HOLD_CYC);
    localparam int          SW      = $clog2(MAX_CYC) + 1;

    lcd_state_t      state;
    logic [SW-1:0]   cnt;

    // Done is combinational so the top can start the next pulse or the
    // execution wait on the very edge the hold period ends.
    assign done = (state == S_EHOLD) && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lcd_data <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lcd_data <= data;
                        lcd_rs   <= rs;
                        cnt      <= SW'(SETUP_CYC - 1);
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b1;
                        cnt   <= SW'(EPW_CYC - 1);
                        state <= S_EHIGH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_EHIGH: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b0;
                        cnt   <= SW'(HOLD_CYC - 1);
                        state <= S_EHOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_EHOLD: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_char_ctrl.sv
// lcd_char_ctrl
// HD44780-compatible character LCD controller. Runs the power-on init
// sequence, then accepts instruction/data bytes over a valid/ready
// handshake and sends them with timed execution waits (no busy polling).
// Optional feature macro: LCD_AUTOWRAP_EN (column/line tracking with
// automatic set-DDRAM-address insertion at the end of a line).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  : byte handshake; transfer on valid && ready
//   cmd_rs, cmd_data     : 0 = instruction, 1 = DDRAM data; byte value
//   init_done            : init sequence finished (sticky until rst)
//   busy                 : registered inverse of cmd_ready
//   lcd_data/e/rs/rw     : LCD pins (rw tied low, write-only)
module lcd_char_ctrl
    import lcd_pkg::*;
#(
    parameter longint unsigned CLK_FREQ_HZ    = 200_000_000,
    parameter int              BUS_WIDTH      = 4,
    parameter int              NUM_LINES      = 2,
    parameter int              CHARS_PER_LINE = 16,
    parameter int unsigned     T_SETUP_NS     = 100,
    parameter int unsigned     T_EPW_NS       = 500,
    parameter int unsigned     T_HOLD_NS      = 500,
    parameter int unsigned     DELAY_DIV      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_rs,
    input  logic [7:0]           cmd_data,
    output logic                 init_done,
    output logic                 busy,
    output logic [BUS_WIDTH-1:0] lcd_data,
    output logic                 lcd_e,
    output logic                 lcd_rs,
    output logic                 lcd_rw
);

    // Bus timing is never divided; ms/us class waits are.
    localparam int unsigned SETUP_CYC = div_cyc(cyc(T_SETUP_NS, CLK_FREQ_HZ), 1);
    localparam int unsigned EPW_CYC   = div_cyc(cyc(T_EPW_NS, CLK_FREQ_HZ), 1);
    localparam int unsigned HOLD_CYC  = div_cyc(cyc(T_HOLD_NS, CLK_FREQ_HZ), 1);
    localparam int unsigned PWRUP_CYC = div_cyc(cyc(T_PWRUP_NS, CLK_FREQ_HZ), DELAY_DIV);
    localparam int unsigned WAKE1_CYC = div_cyc(cyc(T_WAKE1_NS, CLK_FREQ_HZ), DELAY_DIV);
    localparam int unsigned WAKE2_CYC = div_cyc(cyc(T_WAKE2_NS, CLK_FREQ_HZ), DELAY_DIV);
    localparam int unsigned CLEAR_CYC = div_cyc(cyc(T_CLEAR_NS, CLK_FREQ_HZ), DELAY_DIV);
    localparam int unsigned EXEC_CYC  = div_cyc(cyc(T_EXEC_NS, CLK_FREQ_HZ), DELAY_DIV);
    localparam int unsigned MAX_WAIT  = max3(PWRUP_CYC, WAKE1_CYC, CLEAR_CYC);
    localparam int          DW        = $clog2(MAX_WAIT) + 1;

    // Init ROM layout: wake-up steps first (three 0x3 plus 0x2 on a 4-bit
    // bus), then function set, display off, clear, entry mode, display on.
    localparam int FIRST_BYTE = (BUS_WIDTH == 4) ? 4 : 3;
    localparam int LAST_STEP  = FIRST_BYTE + 4;
    localparam logic [7:0] FSET_BASE = (BUS_WIDTH == 4) ? FSET_4B : FSET_8B;
    localparam logic [7:0] FSET = (NUM_LINES == 2) ? FSET_BASE : (FSET_BASE & ~FSET_N_BIT);

    lcd_state_t            state;
    logic [DW-1:0]         dcnt;
    logic [3:0]            step;
    logic [7:0]            tx_byte;
    logic                  tx_rs;
    logic                  tx_single;
    logic [DW-1:0]         tx_wait;
    logic                  phase_low;
    logic                  strobe_start;
    logic                  strobe_done;
    logic [BUS_WIDTH-1:0]  strobe_data;
    logic [7:0]            rom_byte;
    logic                  rom_single;
    logic [DW-1:0]         rom_wait;

`ifdef LCD_AUTOWRAP_EN
    localparam int COL_W = 7;
    logic [COL_W-1:0]      col;
    logic                  line;
    logic                  pending;
    logic [7:0]            pend_byte;
`endif

    assign lcd_rw = 1'b0;

    function automatic logic [DW-1:0] exec_wait(input logic rs, input logic [7:0] data);
        if (!rs && (data == CLEAR || data == HOME || data == 8'h03))
            return DW'(CLEAR_CYC);
        return DW'(EXEC_CYC);
    endfunction

    // Wake-up steps are stored as bytes so the high nibble carries the
    // 4-bit value; they are always a single pulse.
    always_comb begin
        rom_byte   = 8'h30;
        rom_single = 1'b1;
        rom_wait   = DW'(WAKE2_CYC);
        if (step < 4'(FIRST_BYTE)) begin
            rom_byte = (step == 4'd3) ? 8'h20 : 8'h30;
            rom_wait = (step == 4'd0) ? DW'(WAKE1_CYC) : DW'(WAKE2_CYC);
        end else begin
            rom_single = (BUS_WIDTH == 8);
            case (step - 4'(FIRST_BYTE))
                4'd0:    rom_byte = FSET;
                4'd1:    rom_byte = DISP_OFF;
                4'd2:    rom_byte = CLEAR;
                4'd3:    rom_byte = ENTRY_INC;
                default: rom_byte = DISP_ON;
            endcase
            rom_wait = exec_wait(1'b0, rom_byte);
        end
    end

    generate
        if (BUS_WIDTH == 4) begin : g_bus4
            assign strobe_data = phase_low ? tx_byte[3:0] : tx_byte[7:4];
        end else begin : g_bus8
            assign strobe_data = tx_byte;
        end
    endgenerate

    lcd_bus_strobe #(
        .BUS_WIDTH (BUS_WIDTH),
        .SETUP_CYC (SETUP_CYC),
        .EPW_CYC   (EPW_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_strobe (
        .clk      (clk),
        .rst      (rst),
        .start    (strobe_start),
        .rs       (tx_rs),
        .data     (strobe_data),
        .done     (strobe_done),
        .lcd_data (lcd_data),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs)
    );

    // S_SETUP here means "a transfer is on the bus"; the strobe sub-module
    // owns the SETUP/EHIGH/EHOLD detail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_PWRUP;
            dcnt         <= DW'(PWRUP_CYC - 1);
            step         <= '0;
            tx_byte      <= '0;
            tx_rs        <= 1'b0;
            tx_single    <= 1'b0;
            tx_wait      <= '0;
            phase_low    <= 1'b0;
            strobe_start <= 1'b0;
            cmd_ready    <= 1'b0;
            busy         <= 1'b1;
            init_done    <= 1'b0;
`ifdef LCD_AUTOWRAP_EN
            col          <= '0;
            line         <= 1'b0;
            pending      <= 1'b0;
            pend_byte    <= '0;
`endif
        end else begin
            strobe_start <= 1'b0;
            case (state)
                S_PWRUP: begin
                    if (dcnt == '0) begin
                        step  <= '0;
                        state <= S_INIT;
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                S_INIT: begin
                    tx_byte      <= rom_byte;
                    tx_rs        <= 1'b0;
                    tx_single    <= rom_single;
                    tx_wait      <= rom_wait;
                    phase_low    <= 1'b0;
                    strobe_start <= 1'b1;
                    state        <= S_SETUP;
                end
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        phase_low    <= 1'b0;
                        tx_single    <= (BUS_WIDTH == 8);
                        strobe_start <= 1'b1;
                        state        <= S_SETUP;
`ifdef LCD_AUTOWRAP_EN
                        if (cmd_rs && col == COL_W'(CHARS_PER_LINE)) begin
                            // Line full: move the cursor first, send the byte after
                            pending   <= 1'b1;
                            pend_byte <= cmd_data;
                            tx_byte   <= (!line && NUM_LINES == 2) ? DDRAM_L1 : DDRAM_L0;
                            tx_rs     <= 1'b0;
                            tx_wait   <= DW'(EXEC_CYC);
                            line      <= (NUM_LINES == 2) ? ~line : 1'b0;
                            col       <= COL_W'(1);
                        end else begin
                            tx_byte <= cmd_data;
                            tx_rs   <= cmd_rs;
                            tx_wait <= exec_wait(cmd_rs, cmd_data);
                            if (cmd_rs) begin
                                col <= col + 1'b1;
                            end else if (cmd_data == CLEAR) begin
                                col  <= '0;
                                line <= 1'b0;
                            end else if (cmd_data[7]) begin
                                line <= cmd_data[6];
                                col  <= COL_W'(cmd_data[5:0]);
                            end
                        end
`else
                        tx_byte <= cmd_data;
                        tx_rs   <= cmd_rs;
                        tx_wait <= exec_wait(cmd_rs, cmd_data);
`endif
                    end
                end
                S_SETUP: begin
                    if (strobe_done) begin
                        if (!tx_single && !phase_low) begin
                            phase_low    <= 1'b1;
                            strobe_start <= 1'b1;
                        end else begin
                            dcnt  <= tx_wait - 1'b1;
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (dcnt != '0) begin
                        dcnt <= dcnt - 1'b1;
                    end else if (!init_done) begin
                        if (step == 4'(LAST_STEP)) begin
                            init_done <= 1'b1;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            step  <= step + 1'b1;
                            state <= S_INIT;
                        end
`ifdef LCD_AUTOWRAP_EN
                    end else if (pending) begin
                        pending      <= 1'b0;
                        tx_byte      <= pend_byte;
                        tx_rs        <= 1'b1;
                        tx_wait      <= DW'(EXEC_CYC);
                        phase_low    <= 1'b0;
                        strobe_start <= 1'b1;
                        state        <= S_SETUP;
`endif
                    end else begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// tb_lcd_char_ctrl
// Two controllers at 200 MHz with DELAY_DIV=1000: a 4-bit bus instance
// (index 0) and an 8-bit bus instance (index 1). A monitor captures
// {lcd_rs, lcd_data} at every E falling edge plus E/setup/exec timing.
module tb_lcd_char_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic valid4, valid8;
    logic cmd_rs;
    logic [7:0] cmd_data;

    logic cmd_ready4, init_done4, busy4, lcd_e4, lcd_rs4, lcd_rw4;
    logic [3:0] lcd_data4;
    logic cmd_ready8, init_done8, busy8, lcd_e8, lcd_rs8, lcd_rw8;
    logic [7:0] lcd_data8;

    always #2.5 clk = ~clk;

    lcd_char_ctrl #(.BUS_WIDTH(4), .DELAY_DIV(1000)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(valid4), .cmd_ready(cmd_ready4),
        .cmd_rs(cmd_rs), .cmd_data(cmd_data), .init_done(init_done4), .busy(busy4),
        .lcd_data(lcd_data4), .lcd_e(lcd_e4), .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4)
    );

    lcd_char_ctrl #(.BUS_WIDTH(8), .DELAY_DIV(1000)) dut8 (
        .clk(clk), .rst(rst), .cmd_valid(valid8), .cmd_ready(cmd_ready8),
        .cmd_rs(cmd_rs), .cmd_data(cmd_data), .init_done(init_done8), .busy(busy8),
        .lcd_data(lcd_data8), .lcd_e(lcd_e8), .lcd_rs(lcd_rs8), .lcd_rw(lcd_rw8)
    );

    localparam int E_CYC     = 100;
    localparam int SETUP_MIN = 20;
    localparam int HOLD_CYC  = 100;

    int checks = 0;
    int errors = 0;

    logic       mon_e     [2];
    logic       mon_ready [2];
    logic       mon_init  [2];
    logic [8:0] mon_bus   [2];
    assign mon_e[0] = lcd_e4;     assign mon_e[1] = lcd_e8;
    assign mon_ready[0] = cmd_ready4; assign mon_ready[1] = cmd_ready8;
    assign mon_init[0] = init_done4;  assign mon_init[1] = init_done8;
    assign mon_bus[0] = {lcd_rs4, 4'h0, lcd_data4};
    assign mon_bus[1] = {lcd_rs8, lcd_data8};

    int         cyc_cnt = 0;
    logic       e_prev [2];
    logic       ready_prev [2];
    logic       init_prev [2];
    logic [8:0] bus_prev [2];
    int         stable [2];
    int         hi_cnt [2];
    int         min_hi [2], max_hi [2], min_setup [2];
    int         t_fall [2], t_ready [2], t_init [2];
    logic [8:0] cap0 [$];
    logic [8:0] cap1 [$];
    bit         rw_bad = 1'b0;

    always @(negedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (lcd_rw4 !== 1'b0 || lcd_rw8 !== 1'b0) rw_bad = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                e_prev[k] = 1'b0; ready_prev[k] = 1'b0; init_prev[k] = 1'b0;
                bus_prev[k] = '0; stable[k] = 0; hi_cnt[k] = 0;
            end else begin
                if (mon_bus[k] == bus_prev[k]) stable[k] = stable[k] + 1;
                else stable[k] = 1;
                bus_prev[k] = mon_bus[k];
                if (mon_e[k] && !e_prev[k] && (stable[k] - 1) < min_setup[k])
                    min_setup[k] = stable[k] - 1;
                if (mon_e[k]) begin
                    hi_cnt[k] = hi_cnt[k] + 1;
                end else if (e_prev[k]) begin
                    if (hi_cnt[k] < min_hi[k]) min_hi[k] = hi_cnt[k];
                    if (hi_cnt[k] > max_hi[k]) max_hi[k] = hi_cnt[k];
                    hi_cnt[k] = 0;
                    t_fall[k] = cyc_cnt;
                    if (k == 0) cap0.push_back(mon_bus[0]);
                    else        cap1.push_back(mon_bus[1]);
                end
                if (mon_ready[k] && !ready_prev[k]) t_ready[k] = cyc_cnt;
                if (mon_init[k] && !init_prev[k])   t_init[k]  = cyc_cnt;
                e_prev[k] = mon_e[k]; ready_prev[k] = mon_ready[k]; init_prev[k] = mon_init[k];
            end
        end
    end

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         exec_cyc;
    } vec_t;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks = checks + 1;
        if (actual != expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkAtLeast(input string name, input longint actual, input longint minimum);
        checks = checks + 1;
        if (actual < minimum) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%0d required>=%0d", name, actual, minimum);
        end
    endtask

    task automatic resetTiming(input int k);
        min_hi[k] = 1_000_000; max_hi[k] = 0; min_setup[k] = 1_000_000;
    endtask

    task automatic waitReady(input int k, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mon_ready[k]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic waitInit(input int k, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mon_init[k]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic applyStimulus(input int k, input logic rs, input logic [7:0] data);
        bit ok;
        waitReady(k, 3000, ok);
        checkOutput("accept_wait", ok, 1);
        cmd_rs = rs; cmd_data = data;
        if (k == 0) valid4 = 1'b1; else valid8 = 1'b1;
        @(posedge clk); #1;
        valid4 = 1'b0; valid8 = 1'b0;
    endtask

    task automatic checkInit();
        bit ok;
        int init4 [14] = '{'h3, 'h3, 'h3, 'h2, 'h2, 'h8, 'h0, 'h8, 'h0, 'h1, 'h0, 'h6, 'h0, 'hC};
        int init8 [8]  = '{'h30, 'h30, 'h30, 'h38, 'h08, 'h01, 'h06, 'h0C};
        waitInit(0, 20000, ok); checkOutput("init_wait4", ok, 1);
        waitInit(1, 20000, ok); checkOutput("init_wait8", ok, 1);
        @(posedge clk); #1;
        checkOutput("init_ready_same_cycle4", t_init[0], t_ready[0]);
        checkOutput("init_ready_same_cycle8", t_init[1], t_ready[1]);
        checkOutput("busy_after_init4", busy4, 0);
        checkOutput("init_count4", cap0.size(), 14);
        for (int i = 0; i < 14; i++)
            checkOutput($sformatf("init4[%0d]", i), (i < cap0.size()) ? cap0[i] : 9'h1FF, init4[i]);
        checkOutput("init_count8", cap1.size(), 8);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("init8[%0d]", i), (i < cap1.size()) ? cap1[i] : 9'h1FF, init8[i]);
    endtask

    initial begin
        vec_t       vecs [7];
        bit         ok;
        logic [7:0] burst [3];

        vecs[0] = '{1'b1, 8'h41, 8};
        vecs[1] = '{1'b0, 8'h01, 328};
        vecs[2] = '{1'b0, 8'h0C, 8};
        vecs[3] = '{1'b0, 8'h02, 328};
        vecs[4] = '{1'b0, 8'h03, 328};
        vecs[5] = '{1'b0, 8'h04, 8};
        vecs[6] = '{1'b1, 8'h7E, 8};
        burst[0] = 8'h31; burst[1] = 8'h32; burst[2] = 8'h33;

        rst = 1'b1; valid4 = 1'b0; valid8 = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00;
        resetTiming(0); resetTiming(1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", cmd_ready4, 0);
        checkOutput("rst_busy", busy4, 1);
        checkOutput("rst_init_done", init_done4, 0);
        checkOutput("rst_lcd_e", lcd_e4, 0);
        checkOutput("rst_lcd_data", lcd_data4, 0);
        checkOutput("rst_lcd_rs", lcd_rs4, 0);
        rst = 1'b0;
        checkInit();

        // Table-driven single transfers on the 4-bit bus
        for (int v = 0; v < 7; v++) begin
            cap0.delete(); resetTiming(0);
            applyStimulus(0, vecs[v].rs, vecs[v].data);
            waitReady(0, 3000, ok);
            checkOutput($sformatf("v%0d_ready_wait", v), ok, 1);
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_pulses", v), cap0.size(), 2);
            checkOutput($sformatf("v%0d_hi", v), (cap0.size() > 0) ? cap0[0] : 9'h1FF,
                        {vecs[v].rs, 4'h0, vecs[v].data[7:4]});
            checkOutput($sformatf("v%0d_lo", v), (cap0.size() > 1) ? cap0[1] : 9'h1FF,
                        {vecs[v].rs, 4'h0, vecs[v].data[3:0]});
            checkOutput($sformatf("v%0d_e_min", v), min_hi[0], E_CYC);
            checkOutput($sformatf("v%0d_e_max", v), max_hi[0], E_CYC);
            checkAtLeast($sformatf("v%0d_setup", v), min_setup[0], SETUP_MIN);
            checkOutput($sformatf("v%0d_exec", v), t_ready[0] - t_fall[0], HOLD_CYC + vecs[v].exec_cyc);
            checkOutput($sformatf("v%0d_busy", v), busy4, 0);
        end

        // 8-bit bus: one pulse per byte
        cap1.delete(); resetTiming(1);
        applyStimulus(1, 1'b1, 8'h5A);
        waitReady(1, 3000, ok);
        checkOutput("b8_ready_wait", ok, 1);
        @(posedge clk); #1;
        checkOutput("b8_pulses", cap1.size(), 1);
        checkOutput("b8_byte", (cap1.size() > 0) ? cap1[0] : 9'h1FF, 9'h15A);
        checkOutput("b8_e_width", max_hi[1], E_CYC);
        checkOutput("b8_exec", t_ready[1] - t_fall[1], HOLD_CYC + 8);

        // cmd_valid held high across three acceptances
        cap0.delete();
        cmd_rs = 1'b1; cmd_data = burst[0]; valid4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            waitReady(0, 3000, ok);
            checkOutput($sformatf("burst%0d_wait", i), ok, 1);
            @(posedge clk); #1;
            if (i < 2) cmd_data = burst[i + 1];
            else       valid4 = 1'b0;
        end
        waitReady(0, 3000, ok);
        checkOutput("burst_done_wait", ok, 1);
        repeat (50) @(posedge clk);
        #1;
        checkOutput("burst_pulses", cap0.size(), 6);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("burst%0d_hi", i), (2*i < cap0.size()) ? cap0[2*i] : 9'h1FF,
                        {1'b1, 4'h0, burst[i][7:4]});
            checkOutput($sformatf("burst%0d_lo", i), (2*i+1 < cap0.size()) ? cap0[2*i+1] : 9'h1FF,
                        {1'b1, 4'h0, burst[i][3:0]});
        end

        // Reset in the middle of an E pulse
        applyStimulus(0, 1'b1, 8'h55);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (lcd_e4) begin ok = 1'b1; break; end
        end
        checkOutput("ehigh_wait", ok, 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_lcd_e", lcd_e4, 0);
        checkOutput("midrst_lcd_data", lcd_data4, 0);
        checkOutput("midrst_lcd_rs", lcd_rs4, 0);
        checkOutput("midrst_ready", cmd_ready4, 0);
        checkOutput("midrst_busy", busy4, 1);
        checkOutput("midrst_init_done", init_done4, 0);
        repeat (3) @(posedge clk);
        #1;
        cap0.delete(); cap1.delete();
        rst = 1'b0;
        checkInit();

`ifdef LCD_AUTOWRAP_EN
        cap1.delete();
        for (int i = 0; i < 17; i++) applyStimulus(1, 1'b1, 8'(8'h41 + i));
        waitReady(1, 3000, ok);
        checkOutput("wrap_done_wait", ok, 1);
        @(posedge clk); #1;
        checkOutput("wrap_pulses", cap1.size(), 18);
        checkOutput("wrap_16th", (cap1.size() > 15) ? cap1[15] : 9'h1FF, 9'h150);
        checkOutput("wrap_addr", (cap1.size() > 16) ? cap1[16] : 9'h1FF, 9'h0C0);
        checkOutput("wrap_17th", (cap1.size() > 17) ? cap1[17] : 9'h1FF, 9'h151);
`endif

        checkOutput("lcd_rw_low", rw_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
